spi_frame_slave: RTL

- Parametrised SPI slave front end for the host command link.
- Receives a frame of `NUM_WORDS` words of `WORD_BITS` bits each, MSB first, from the external master and presents it as a parallel, word-indexed register.
- Shifts the previous status frame back out on `sdo` during the same transfer.
- Sits between the host pins (`sclk`, `sdi`, `load`, `sdo`) and the motor/laser/ADC control logic. Everything runs in the system `clk` domain, with the SPI pins treated as asynchronous.

---
 rtl/spi_frame_slave_if.sv | 30 +++
 rtl/spi_frame_slave.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave_if.sv
// Pin and parallel-side bundle for spi_frame_slave.
// The slave modport is the design side; the master modport is the host/bench side.
interface spi_frame_slave_if #(
    parameter int WORD_BITS = 8,
    parameter int NUM_WORDS = 8
);
    localparam int FRAME_BITS = WORD_BITS * NUM_WORDS;
    localparam int CNT_BITS   = $clog2(FRAME_BITS + 2);

    logic                                 sclk;
    logic                                 sdi;
    logic                                 load;
    logic                                 sdo;
    logic [FRAME_BITS-1:0]                tx_data;
    logic [NUM_WORDS-1:0][WORD_BITS-1:0]  rx_data;
    logic                                 frame_valid;
    logic                                 frame_err;
    logic                                 busy;
    logic [CNT_BITS-1:0]                  bit_count;

    modport slave (
        input  sclk, sdi, load, tx_data,
        output sdo, rx_data, frame_valid, frame_err, busy, bit_count
    );

    modport master (
        output sclk, sdi, load, tx_data,
        input  sdo, rx_data, frame_valid, frame_err, busy, bit_count
    );
endinterface

// File: rtl/spi_frame_slave.sv
// SPI frame slave: receives a NUM_WORDS x WORD_BITS frame on sdi and returns the status frame on sdo.
// Optional trailing even-parity bit is enabled by defining SPI_FRAME_PARITY_EN.
module spi_frame_slave #(
    parameter int WORD_BITS   = 8,
    parameter int NUM_WORDS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    spi_frame_slave_if.slave    bus
);
    localparam int FRAME_BITS = WORD_BITS * NUM_WORDS;
`ifdef SPI_FRAME_PARITY_EN
    localparam int FRAME_LEN  = FRAME_BITS + 1;
`else
    localparam int FRAME_LEN  = FRAME_BITS;
`endif
    localparam int CNT_BITS   = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_BITS-1:0] FRAME_LEN_C = CNT_BITS'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

`ifdef SPI_FRAME_PARITY_EN
    function automatic logic even_parity(input logic [FRAME_BITS-1:0] data);
        return ^data;
    endfunction
`endif

    // Wire-order image of the status frame: data MSB first, then the parity bit if enabled.
    function automatic logic [FRAME_LEN-1:0] tx_frame(input logic [FRAME_BITS-1:0] data);
`ifdef SPI_FRAME_PARITY_EN
        return {data, even_parity(data)};
`else
        return data;
`endif
    endfunction

    logic [SYNC_STAGES-1:0]              sclk_sync_q;
    logic [SYNC_STAGES-1:0]              sdi_sync_q;
    logic [SYNC_STAGES-1:0]              load_sync_q;
    logic                                sclk_edge_q;
    logic                                load_edge_q;

    state_t                              state_q;
    logic [FRAME_LEN-1:0]                tx_sr_q;
    logic [FRAME_LEN-1:0]                rx_sr_q;
    logic [CNT_BITS-1:0]                 bit_cnt_q;
    logic                                ovf_q;
    logic [NUM_WORDS-1:0][WORD_BITS-1:0] rx_data_q;
    logic                                sdo_q;
    logic                                frame_valid_q;
    logic                                frame_err_q;
    logic                                busy_q;

    logic                                sclk_rise_s;
    logic                                sclk_fall_s;
    logic                                load_rise_s;
    logic                                load_fall_s;
    logic                                sdi_s;
    logic                                parity_ok_s;
    logic                                frame_ok_s;
    logic [FRAME_LEN-1:0]                rx_sr_d;
    logic [CNT_BITS-1:0]                 bit_cnt_d;
    logic                                ovf_d;

    // Bring the asynchronous SPI pins into the clk domain, with one extra stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            load_sync_q <= '0;
            sclk_edge_q <= 1'b0;
            load_edge_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0],  bus.sdi};
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], bus.load};
            sclk_edge_q <= sclk_sync_q[SYNC_STAGES-1];
            load_edge_q <= load_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_s = sclk_sync_q[SYNC_STAGES-1] & ~sclk_edge_q;
    assign sclk_fall_s = ~sclk_sync_q[SYNC_STAGES-1] & sclk_edge_q;
    assign load_rise_s = load_sync_q[SYNC_STAGES-1] & ~load_edge_q;
    assign load_fall_s = ~load_sync_q[SYNC_STAGES-1] & load_edge_q;
    assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];

    // Receive-side next state; a bit arriving with the load fall is counted before the frame is judged.
    always_comb begin
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        ovf_d     = ovf_q;
        if (sclk_rise_s) begin
            if (bit_cnt_q < FRAME_LEN_C) begin
                rx_sr_d   = {rx_sr_q[FRAME_LEN-2:0], sdi_s};
                bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
            end else begin
                ovf_d     = 1'b1;
            end
        end else begin
            rx_sr_d   = rx_sr_q;
        end
    end

`ifdef SPI_FRAME_PARITY_EN
    // Data plus received parity bit must contain an even number of ones.
    assign parity_ok_s = ~(^rx_sr_d);
`else
    assign parity_ok_s = 1'b1;
`endif

    assign frame_ok_s = (bit_cnt_d == FRAME_LEN_C) && !ovf_d && parity_ok_s;

    // Frame state machine with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            bit_cnt_q     <= '0;
            ovf_q         <= 1'b0;
            rx_data_q     <= '0;
            sdo_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            // The extra sdo stage lets the master sample a settled bit on the next sclk rise.
            sdo_q         <= tx_sr_q[FRAME_LEN-1];
            case (state_q)
                ST_IDLE: begin
                    if (load_rise_s) begin
                        tx_sr_q   <= tx_frame(bus.tx_data);
                        bit_cnt_q <= '0;
                        ovf_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    rx_sr_q   <= rx_sr_d;
                    bit_cnt_q <= bit_cnt_d;
                    ovf_q     <= ovf_d;
                    if (sclk_fall_s) begin
                        tx_sr_q <= {tx_sr_q[FRAME_LEN-2:0], 1'b0};
                    end
                    if (load_fall_s) begin
                        if (frame_ok_s) begin
                            rx_data_q     <= rx_sr_d[FRAME_LEN-1 -: FRAME_BITS];
                            frame_valid_q <= 1'b1;
                            state_q       <= ST_COMMIT;
                        end else begin
                            frame_err_q   <= 1'b1;
                            state_q       <= ST_DISCARD;
                        end
                    end
                end
                ST_COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_DISCARD: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sdo         = sdo_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;
    assign bus.bit_count   = bit_cnt_q;
endmodule
